ft245_fifo_if: RTL and testbench



---
 rtl/ft245_pkg.sv | 20 ++
 rtl/ft245_fifo_if.sv | 144 ++++++++++++++
 tb/tb_ft245_fifo_if.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/ft245_pkg.sv
// rtl/ft245_pkg.sv - shared state encoding and timing defaults for the FT245 FIFO controller
package ft245_pkg;

  localparam int CNT_W = 4;

  localparam int unsigned RD_CYC_DEF       = 4;
  localparam int unsigned WR_SETUP_CYC_DEF = 1;
  localparam int unsigned WR_CYC_DEF       = 4;
  localparam int unsigned RECOVER_CYC_DEF  = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR_SETUP,
    S_WR,
    S_WR_HOLD,
    S_RECOVER
  } ft245_state_e;

endpackage

// File: rtl/ft245_fifo_if.sv
// rtl/ft245_fifo_if.sv - FT245 parallel FIFO byte-stream controller with round-robin read/write arbitration
module ft245_fifo_if
  import ft245_pkg::*;
#(
  parameter int unsigned RD_CYC       = RD_CYC_DEF,
  parameter int unsigned WR_SETUP_CYC = WR_SETUP_CYC_DEF,
  parameter int unsigned WR_CYC       = WR_CYC_DEF,
  parameter int unsigned RECOVER_CYC  = RECOVER_CYC_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] uart_rdata,
  output logic [7:0] uart_wdata,
  input  logic       uart_txe,
  input  logic       uart_rxf,
  output logic       uart_wr,
  output logic       uart_rd,
  output logic       uart_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready
);

  localparam logic [CNT_W-1:0] RD_CNT  = CNT_W'(RD_CYC);
  localparam logic [CNT_W-1:0] WS_CNT  = CNT_W'(WR_SETUP_CYC);
  localparam logic [CNT_W-1:0] WR_CNT  = CNT_W'(WR_CYC);
  localparam logic [CNT_W-1:0] REC_CNT = CNT_W'(RECOVER_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  ft245_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_wr_q, last_wr_d;
  logic             rd_q, rd_d, wr_q, wr_d, oe_q, oe_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             rd_ok, wr_ok;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_wr_d  = last_wr_q;
    wdata_d    = wdata_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    tx_ready   = 1'b0;

    rd_ok = !uart_rxf && !rx_valid_q;
    wr_ok = !uart_txe && tx_valid;

    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Ties go to whichever side was not served last.
        if (rd_ok && (!wr_ok || last_wr_q)) begin
          state_d   = S_RD;
          cnt_d     = RD_CNT;
          last_wr_d = 1'b0;
        end else if (wr_ok) begin
          state_d   = S_WR_SETUP;
          cnt_d     = WS_CNT;
          last_wr_d = 1'b1;
          tx_ready  = 1'b1;
          wdata_d   = tx_data;
        end
      end
      S_RD: begin
        // Strobe spans counts RD_CYC..1; count 0 is the strobe-low cycle before recovery.
        if (cnt_q == CNT_ONE) begin
          rx_data_d  = uart_rdata;
          rx_valid_d = 1'b1;
        end
        if (cnt_q == '0) begin
          state_d = S_RECOVER;
          cnt_d   = REC_CNT;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_WR_SETUP: begin
        if (cnt_q == CNT_ONE) begin
          state_d = S_WR;
          cnt_d   = WR_CNT;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_WR: begin
        if (cnt_q == CNT_ONE) state_d = S_WR_HOLD;
        else                  cnt_d   = cnt_q - CNT_ONE;
      end
      S_WR_HOLD: begin
        state_d = S_RECOVER;
        cnt_d   = REC_CNT;
      end
      S_RECOVER: begin
        if (cnt_q == CNT_ONE) state_d = S_IDLE;
        else                  cnt_d   = cnt_q - CNT_ONE;
      end
      default: state_d = S_IDLE;
    endcase

    // Pad strobes are registered from the next state so they never glitch.
    rd_d = (state_d == S_RD) && (cnt_d != '0);
    wr_d = (state_d == S_WR);
    oe_d = (state_d == S_WR_SETUP) || (state_d == S_WR) || (state_d == S_WR_HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      last_wr_q  <= 1'b1;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      oe_q       <= 1'b0;
      wdata_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_wr_q  <= last_wr_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      oe_q       <= oe_d;
      wdata_q    <= wdata_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign uart_rd    = rd_q;
  assign uart_wr    = wr_q;
  assign uart_oe    = oe_q;
  assign uart_wdata = wdata_q;
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;

endmodule

// File: tb/tb_ft245_fifo_if.sv
// tb/tb_ft245_fifo_if.sv - self-checking bench for ft245_fifo_if against a transaction-timing model
module tb_ft245_fifo_if;

  localparam int RD  = 4;
  localparam int WS  = 1;
  localparam int WC  = 4;
  localparam int REC = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] uart_rdata, uart_wdata, rx_data, tx_data;
  logic       uart_txe, uart_rxf, uart_wr, uart_rd, uart_oe;
  logic       rx_valid, rx_ready, tx_valid, tx_ready;

  ft245_fifo_if dut (
    .clk(clk), .rst_n(rst_n),
    .uart_rdata(uart_rdata), .uart_wdata(uart_wdata),
    .uart_txe(uart_txe), .uart_rxf(uart_rxf),
    .uart_wr(uart_wr), .uart_rd(uart_rd), .uart_oe(uart_oe),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: each transfer is a grant cycle g plus fixed windows derived from the timing parameters.
  int       t;
  int       free_t;
  int       g;
  int       kind;      // 0 none, 1 read, 2 write
  bit       last_wr;
  bit       m_rxv;
  bit [7:0] m_rxd;
  bit [7:0] m_wd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h cycle=%0d", tag, obs, exp, t);
    end
  endtask

  task automatic model_reset();
    t = -1; free_t = 0; g = 0; kind = 0;
    last_wr = 1'b1; m_rxv = 1'b0; m_rxd = 8'h00; m_wd = 8'h00;
  endtask

  task automatic idle_inputs();
    uart_rxf = 1'b1; uart_txe = 1'b1; tx_valid = 1'b0; rx_ready = 1'b0;
    uart_rdata = 8'h00; tx_data = 8'h00;
  endtask

  task automatic drive(input int mode);
    case (mode)
      0: begin uart_rxf = 0; uart_txe = 1; tx_valid = 0; rx_ready = 1; uart_rdata = 8'hA5; end
      1: begin uart_rxf = 1; uart_txe = 0; tx_valid = 1; rx_ready = 1; tx_data = 8'h3C; end
      2: begin uart_rxf = 0; uart_txe = 0; tx_valid = 1; rx_ready = 1;
               uart_rdata = 8'($urandom); tx_data = 8'($urandom); end
      3: begin uart_rxf = 0; uart_txe = 1; tx_valid = 0; rx_ready = 0; uart_rdata = 8'h5A; end
      5: begin uart_rxf = 1; uart_txe = 1; tx_valid = 1; rx_ready = 1; tx_data = 8'h3C; end
      default: begin
        uart_rxf   = ($urandom_range(0, 3) == 0);
        uart_txe   = ($urandom_range(0, 3) == 0);
        tx_valid   = ($urandom_range(0, 1) == 1);
        rx_ready   = ($urandom_range(0, 2) != 0);
        uart_rdata = 8'($urandom);
        tx_data    = 8'($urandom);
      end
    endcase
  endtask

  task automatic step(input int mode);
    bit exp_rd, exp_wr, exp_oe, idle, rd_ok, wr_ok, gr_rd, gr_wr;
    @(posedge clk);
    t++;
    #1;
    drive(mode);
    @(negedge clk);
    exp_rd = (kind == 1) && (t >= g + 1) && (t <= g + RD);
    exp_oe = (kind == 2) && (t >= g + 1) && (t <= g + WS + WC + 1);
    exp_wr = (kind == 2) && (t >= g + 1 + WS) && (t <= g + WS + WC);
    idle   = (t >= free_t);
    rd_ok  = !uart_rxf && !m_rxv;
    wr_ok  = !uart_txe && tx_valid;
    gr_rd  = idle && rd_ok && (!wr_ok || last_wr);
    gr_wr  = idle && wr_ok && !gr_rd;

    chk("uart_rd", 32'(uart_rd), 32'(exp_rd));
    chk("uart_wr", 32'(uart_wr), 32'(exp_wr));
    chk("uart_oe", 32'(uart_oe), 32'(exp_oe));
    chk("tx_ready", 32'(tx_ready), 32'(gr_wr));
    chk("uart_wdata", 32'(uart_wdata), 32'(m_wd));
    chk("rx_valid", 32'(rx_valid), 32'(m_rxv));
    chk("rx_data", 32'(rx_data), 32'(m_rxd));
    chk("rd_and_oe", 32'(uart_rd & uart_oe), 32'd0);

    if (m_rxv && rx_ready) m_rxv = 1'b0;
    if (kind == 1 && t == g + RD) begin
      m_rxv = 1'b1;
      m_rxd = uart_rdata;
    end
    if (gr_rd) begin
      kind = 1; g = t; last_wr = 1'b0; free_t = t + 1 + RD + 1 + REC;
    end else if (gr_wr) begin
      kind = 2; g = t; last_wr = 1'b1; m_wd = tx_data; free_t = t + 1 + WS + WC + 1 + REC;
    end
  endtask

  task automatic run(input int n, input int mode);
    for (int i = 0; i < n; i++) step(mode);
  endtask

  initial begin
    rst_n = 1'b1;
    idle_inputs();
    model_reset();
    #1 rst_n = 1'b0;
    #2;
    chk("rst_uart_rd", 32'(uart_rd), 32'd0);
    chk("rst_uart_wr", 32'(uart_wr), 32'd0);
    chk("rst_uart_oe", 32'(uart_oe), 32'd0);
    chk("rst_uart_wdata", 32'(uart_wdata), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run(25, 0);   // back-to-back reads of 0xA5
    run(25, 1);   // back-to-back writes of 0x3C
    run(45, 2);   // both sides eligible: alternating, read first
    run(30, 3);   // consumer stalled holding 0x5A
    run(20, 0);   // consumer releases, reads resume
    run(10, 5);   // FIFO full: tx held off
    run(15, 1);   // FIFO drains: write starts

    for (int k = 0; k < 30 && !(kind == 2 && t == g + 1 + WS + 1); k++) step(1);
    chk("reach_wr_cycle2", 32'(kind == 2 && t == g + 1 + WS + 1), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_uart_wr", 32'(uart_wr), 32'd0);
    chk("async_rst_uart_oe", 32'(uart_oe), 32'd0);
    chk("async_rst_uart_rd", 32'(uart_rd), 32'd0);
    chk("async_rst_rx_valid", 32'(rx_valid), 32'd0);
    idle_inputs();
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run(400, 4);  // randomized traffic

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
